// File: rtl/load_store_unit_if.sv
// Core request/response and data-RAM port bundle for the load/store unit.
// The slave modport is the unit's view; the master modport is the core and RAM side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wenable;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wdata, mem_wenable
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wdata, mem_wenable
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: splits misaligned accesses into up to two word beats on a
// single-port RAM, steers store lanes and assembles/extends load data.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

    state_e      state;
    logic        write_q;
    logic        crossing_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [3:0]  wen_hi_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] rbuf_q;

    logic        legal;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic [63:0] rd_beats;
    logic [31:0] rd_word;
    logic [31:0] load_val;
    logic [31:0] resp_val;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH];

    // Byte mask and data spread across two words: low half is beat 0, high half beat 1.
    always_comb begin
        size_mask = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = {4'b0000, size_mask} << bus.req_addr[1:0];
        lane_data = {32'd0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
        legal     = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    // In the last beat the current RAM word sits above the word captured in beat 0.
    always_comb begin
        rd_beats = (state == StBeat1) ? {bus.mem_rdata, rbuf_q} : {32'd0, bus.mem_rdata};
        rd_word  = rd_beats[{off_q, 3'b000} +: 32];
        case (funct3_q)
            3'b000:  load_val = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  load_val = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b100:  load_val = {24'd0, rd_word[7:0]};
            3'b101:  load_val = {16'd0, rd_word[15:0]};
            default: load_val = rd_word;
        endcase
        resp_val = write_q ? 32'd0 : load_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            bus.req_ready   <= 1'b1;
            bus.resp_valid  <= 1'b0;
            bus.resp_error  <= 1'b0;
            bus.resp_rdata  <= 32'd0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= 32'd0;
            bus.mem_wenable <= 4'b0000;
            write_q         <= 1'b0;
            crossing_q      <= 1'b0;
            funct3_q        <= 3'b000;
            off_q           <= 2'b00;
            wen_hi_q        <= 4'b0000;
            wdata_hi_q      <= 32'd0;
            rbuf_q          <= 32'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        write_q       <= bus.req_write;
                        funct3_q      <= bus.req_funct3;
                        off_q         <= bus.req_addr[1:0];
                        crossing_q    <= |lane_mask[7:4];
                        wen_hi_q      <= bus.req_write ? lane_mask[7:4] : 4'b0000;
                        wdata_hi_q    <= bus.req_write ? lane_data[63:32] : 32'd0;
                        if (legal) begin
                            state           <= StBeat0;
                            bus.mem_addr    <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.mem_wenable <= bus.req_write ? lane_mask[3:0] : 4'b0000;
                            bus.mem_wdata   <= bus.req_write ? lane_data[31:0] : 32'd0;
                        end else begin
                            state          <= StDone;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                        end
                    end
                end
                StBeat0: begin
                    rbuf_q <= bus.mem_rdata;
                    if (crossing_q) begin
                        state           <= StBeat1;
                        bus.mem_addr    <= bus.mem_addr + ADDR_WIDTH'(4);
                        bus.mem_wenable <= wen_hi_q;
                        bus.mem_wdata   <= wdata_hi_q;
                    end else begin
                        state           <= StDone;
                        bus.mem_wenable <= 4'b0000;
                        bus.resp_valid  <= 1'b1;
                        bus.resp_error  <= 1'b0;
                        bus.resp_rdata  <= resp_val;
                    end
                end
                StBeat1: begin
                    state           <= StDone;
                    bus.mem_wenable <= 4'b0000;
                    bus.resp_valid  <= 1'b1;
                    bus.resp_error  <= 1'b0;
                    bus.resp_rdata  <= resp_val;
                end
                StDone: begin
                    state          <= StIdle;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array RAM model, directed corner cases
// and randomized accesses checked against a byte-level reference memory.
module tb_load_store_unit;

    localparam int unsigned AW        = 14;
    localparam int unsigned MEM_BYTES = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();
    load_store_unit #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0]    ram [MEM_BYTES];
    logic [7:0]    ref_mem [MEM_BYTES];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [7:0]    poke_data = 8'd0;

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        for (int i = 0; i < 4; i++)
            if (bus.mem_wenable[i]) ram[{bus.mem_addr[AW-1:2], 2'(i)}] <= bus.mem_wdata[8*i +: 8];
    end

    assign bus.mem_rdata = {ram[{bus.mem_addr[AW-1:2], 2'd3}], ram[{bus.mem_addr[AW-1:2], 2'd2}],
                            ram[{bus.mem_addr[AW-1:2], 2'd1}], ram[{bus.mem_addr[AW-1:2], 2'd0}]};

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] beat_addr [4];
    logic [3:0]    beat_wen [4];
    logic [31:0]   beat_wdata [4];
    int            nbeats;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] addr);
        if (!is_legal(f3)) return 0;
        return (int'(addr[1:0]) + size_of(f3) > 4) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0]   v;
        logic [AW-1:0] idx;
        v = 32'd0;
        for (int n = 0; n < size_of(f3); n++) begin
            idx = AW'(addr + 32'(n));
            v   = v | (32'(ref_mem[idx]) << (8 * n));
        end
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [AW-1:0] idx;
        for (int n = 0; n < size_of(f3); n++) begin
            idx          = AW'(addr + 32'(n));
            ref_mem[idx] = wd[8*n +: 8];
        end
    endtask

    // ---------------- drivers ----------------
    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic fill_region(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk);
            poke_en = 1'b1; poke_addr = AW'(a); poke_data = 8'($urandom);
            ref_mem[a] = poke_data;
        end
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL handshake_timeout: req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        nbeats = 0;
        while (bus.resp_valid !== 1'b1 && lat < 10) begin
            if (nbeats < 4) begin
                beat_addr[nbeats]  = bus.mem_addr;
                beat_wen[nbeats]   = bus.mem_wenable;
                beat_wdata[nbeats] = bus.mem_wdata;
                nbeats++;
            end
            @(posedge clk); #1;
            lat++;
        end
        rd  = bus.resp_rdata;
        err = bus.resp_error;
        checks++;
        if (lat >= 10) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid=%b required 1 within 10 cycles", bus.resp_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error: got %b want 0", bus.resp_error); end
        checks++; if (bus.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        checks++; if (bus.mem_wenable !== 4'b0000) begin errors++; $display("FAIL reset_wenable: got %b want 0000", bus.mem_wenable); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        fill_region(0, 16'h03FF);
        fill_region(16'h3C00, 16'h3FFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_load_word();
        logic [31:0] rd; logic err; int lat;
        poke(14'h100, 8'hEF); poke(14'h101, 8'hBE); poke(14'h102, 8'hAD); poke(14'h103, 8'hDE);
        access(1'b0, 3'b010, 32'h100, 32'd0, rd, err, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lw_latency: got %0d want 1", lat); end
        checks++; if (beat_addr[0] !== 14'h100) begin errors++; $display("FAIL lw_mem_addr: got %h want 0100", beat_addr[0]); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_error: got %b want 0", err); end
    endtask

    task automatic test_load_byte();
        logic [31:0] rd; logic err; int lat;
        poke(14'h100, 8'h33); poke(14'h101, 8'h22); poke(14'h102, 8'h11); poke(14'h103, 8'h80);
        access(1'b0, 3'b000, 32'h103, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL lb_latency: got %0d want 1", lat); end
        access(1'b0, 3'b100, 32'h103, 32'd0, rd, err, lat);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", rd); end
    endtask

    task automatic test_store_cross();
        logic [31:0] rd; logic err; int lat;
        access(1'b1, 3'b001, 32'h203, 32'h1234ABCD, rd, err, lat);
        model_store(3'b001, 32'h203, 32'h1234ABCD);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sh_latency: got %0d want 2", lat); end
        checks++; if (beat_addr[0] !== 14'h200 || beat_wen[0] !== 4'b1000 || beat_wdata[0][31:24] !== 8'hCD) begin
            errors++; $display("FAIL sh_beat0: addr=%h wen=%b lane3=%h want 0200 1000 cd", beat_addr[0], beat_wen[0], beat_wdata[0][31:24]);
        end
        checks++; if (beat_addr[1] !== 14'h204 || beat_wen[1] !== 4'b0001 || beat_wdata[1][7:0] !== 8'hAB) begin
            errors++; $display("FAIL sh_beat1: addr=%h wen=%b lane0=%h want 0204 0001 ab", beat_addr[1], beat_wen[1], beat_wdata[1][7:0]);
        end
        checks++; if (ram[14'h203] !== 8'hCD || ram[14'h204] !== 8'hAB) begin
            errors++; $display("FAIL sh_ram: got %h %h want cd ab", ram[14'h203], ram[14'h204]);
        end
        checks++; if (rd !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL sh_resp: rdata=%h err=%b want 0 0", rd, err); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic err; int lat;
        poke(14'h3FFE, 8'h11); poke(14'h3FFF, 8'h22); poke(14'h0000, 8'h33); poke(14'h0001, 8'h44);
        access(1'b0, 3'b010, 32'h3FFE, 32'd0, rd, err, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wrap_latency: got %0d want 2", lat); end
        checks++; if (beat_addr[0] !== 14'h3FFC || beat_addr[1] !== 14'h0000) begin
            errors++; $display("FAIL wrap_mem_addr: got %h %h want 3ffc 0000", beat_addr[0], beat_addr[1]);
        end
        checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL wrap_rdata: got %h want 44332211", rd); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic err; int lat;
        logic [2:0]  bad [3];
        bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;
        for (int i = 0; i < 6; i++) begin
            access(i < 3, bad[i % 3], {22'($urandom), 10'($urandom)}, $urandom, rd, err, lat);
            checks++; if (err !== 1'b1 || rd !== 32'd0) begin
                errors++; $display("FAIL illegal_resp[%0d]: err=%b rdata=%h want 1 0", i, err, rd);
            end
            checks++; if (lat !== 0 || nbeats !== 0 || bus.mem_wenable !== 4'b0000) begin
                errors++; $display("FAIL illegal_skip[%0d]: lat=%0d beats=%0d wen=%b want 0 0 0000", i, lat, nbeats, bus.mem_wenable);
            end
        end
    endtask

    task automatic rand_op(output logic wr, output logic [2:0] f3, output logic [31:0] addr);
        logic [2:0] legal_codes [5];
        legal_codes[0] = 3'b000; legal_codes[1] = 3'b001; legal_codes[2] = 3'b010;
        legal_codes[3] = 3'b100; legal_codes[4] = 3'b101;
        wr   = 1'($urandom);
        f3   = legal_codes[$urandom_range(0, 4)];
        addr = {18'($urandom), ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 16'h03FF))
                                                           : 14'($urandom_range(16'h3C00, 16'h3FFF))};
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, addr, exp; logic err, wr; logic [2:0] f3; int lat;
        for (int i = 0; i < 8; i++) begin
            rand_op(wr, f3, addr);
            exp = wr ? 32'd0 : model_load(f3, addr);
            access(wr, f3, addr, $urandom, rd, err, lat);
            if (wr) model_store(f3, addr, bus.req_wdata);
            checks++; if (rd !== exp) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd, exp); end
            checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_done[%0d]: got %b want 0", i, bus.req_ready); end
            @(posedge clk); #1;
            checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== exp) begin
                errors++; $display("FAIL b2b_idle[%0d]: ready=%b valid=%b rdata=%h want 1 0 %h", i, bus.req_ready, bus.resp_valid, bus.resp_rdata, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp; logic err, wr; logic [2:0] f3; int lat, exp_lat;
        logic [AW-1:0] idx;
        for (int i = 0; i < 150; i++) begin
            rand_op(wr, f3, addr);
            if ($urandom_range(0, 9) == 0) f3 = 3'b011;
            wd      = $urandom;
            exp     = (wr || !is_legal(f3)) ? 32'd0 : model_load(f3, addr);
            exp_lat = model_lat(f3, addr);
            access(wr, f3, addr, wd, rd, err, lat);
            checks++; if (rd !== exp || err !== !is_legal(f3)) begin
                errors++; $display("FAIL rand_resp[%0d] f3=%b addr=%h: rdata=%h err=%b want %h %b", i, f3, addr, rd, err, exp, !is_legal(f3));
            end
            checks++; if (lat !== exp_lat) begin
                errors++; $display("FAIL rand_latency[%0d] f3=%b addr=%h: got %0d want %0d", i, f3, addr, lat, exp_lat);
            end
            if (wr && is_legal(f3)) begin
                model_store(f3, addr, wd);
                for (int n = 0; n < size_of(f3); n++) begin
                    idx = AW'(addr + 32'(n));
                    checks++; if (ram[idx] !== ref_mem[idx]) begin
                        errors++; $display("FAIL rand_store_byte[%0d] addr=%h: got %h want %h", i, idx, ram[idx], ref_mem[idx]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int n, pulses;
        for (int a = 16'h300; a < 16'h308; a++) poke(AW'(a), 8'hA5);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h302; bus.req_wdata = 32'h11223344;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_wenable !== 4'b0000) begin errors++; $display("FAIL abort_wenable: got %b want 0000", bus.mem_wenable); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1) pulses++;
        end
        ref_mem[14'h302] = 8'h44;
        ref_mem[14'h303] = 8'h33;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_resp_valid: got %0d pulses want 0", pulses); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (ram[14'h302] !== 8'h44 || ram[14'h303] !== 8'h33 || ram[14'h304] !== 8'hA5 || ram[14'h305] !== 8'hA5) begin
            errors++; $display("FAIL abort_ram: got %h %h %h %h want 44 33 a5 a5", ram[14'h302], ram[14'h303], ram[14'h304], ram[14'h305]);
        end
    endtask

    task automatic test_final_memory();
        int bad;
        bad = 0;
        for (int a = 0; a < MEM_BYTES; a++)
            if ((a <= 16'h03FF || a >= 16'h3C00) && ram[a] !== ref_mem[a]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL final_memory: %0d bytes differ, want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_cross();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_final_memory();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
